// File: rtl/tag_rx_hop_integrator.sv
// tag_rx_hop_integrator: per-hop coherent I/Q window integrator with settle skip and single-entry output buffer
module tag_rx_hop_integrator #(
  parameter int DATA_WIDTH = 16,
  parameter int NHOP_WIDTH = 7,
  parameter int ACC_LOG2   = 10,
  parameter int SKIP       = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 rx_valid,
  input  logic signed [DATA_WIDTH-1:0]         irx_in,
  input  logic signed [DATA_WIDTH-1:0]         qrx_in,
  input  logic        [NHOP_WIDTH-1:0]         nhop,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic signed [DATA_WIDTH+ACC_LOG2-1:0] o_i_sum,
  output logic signed [DATA_WIDTH+ACC_LOG2-1:0] o_q_sum,
  output logic        [NHOP_WIDTH-1:0]         o_hop,
  output logic        [15:0]                   o_win_idx,
  output logic        [15:0]                   drop_cnt
);
  localparam int SW = DATA_WIDTH + ACC_LOG2;
  localparam int CW = ACC_LOG2 > 16 ? ACC_LOG2 : 16;
  localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'((1 << ACC_LOG2) - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;
  state_t                state;
  logic [NHOP_WIDTH-1:0] hop;
  logic [CW-1:0]         cnt;
  logic signed [SW-1:0]  acc_i, acc_q, sum_i, sum_q;
  logic [15:0]           win;
  logic                  hop_chg, free;
  assign hop_chg = state != IDLE && nhop != hop;
  assign free    = !o_valid || o_ready;
  assign sum_i   = acc_i + {{ACC_LOG2{irx_in[DATA_WIDTH-1]}}, irx_in};
  assign sum_q   = acc_q + {{ACC_LOG2{qrx_in[DATA_WIDTH-1]}}, qrx_in};
  // Hop tracking, settle/accumulate sequencing and the registered output buffer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      hop       <= '0;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      win       <= '0;
      o_valid   <= 1'b0;
      o_i_sum   <= '0;
      o_q_sum   <= '0;
      o_hop     <= '0;
      o_win_idx <= '0;
      drop_cnt  <= '0;
    end else begin
      if (o_valid && o_ready) o_valid <= 1'b0;
      if (state == IDLE || hop_chg) begin
        if (rx_valid || hop_chg) begin
          hop   <= nhop;
          acc_i <= '0;
          acc_q <= '0;
          win   <= '0;
          state <= rx_valid && SKIP_LAST == '0 ? ACCUM : SETTLE;
          cnt   <= rx_valid && SKIP_LAST != '0 ? CW'(1) : '0;
        end
      end else if (rx_valid) begin
        if (state == SETTLE) begin
          state <= cnt == SKIP_LAST ? ACCUM : SETTLE;
          cnt   <= cnt == SKIP_LAST ? '0 : cnt + 1'b1;
        end else if (cnt == WIN_LAST) begin
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
          win   <= win + 1'b1;
          if (free) begin
            o_valid   <= 1'b1;
            o_i_sum   <= sum_i;
            o_q_sum   <= sum_q;
            o_hop     <= hop;
            o_win_idx <= win;
          end else if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
